// File: rtl/sap_safe_reg_responder.sv
// OBI responder for the safe-CPU CSR window: a bank of byte-writable config
// registers plus error bookkeeping (ERR_CNT, LAST_ERR_ADDR), 1-cycle responses.
module sap_safe_reg_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] ERR_RDATA = 32'hBADA_CCE5
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_i,
    output logic                       gnt_o,
    input  logic [31:0]                addr_i,
    input  logic                       we_i,
    input  logic [3:0]                 be_i,
    input  logic [31:0]                wdata_i,
    output logic                       rvalid_o,
    output logic [31:0]                rdata_o,
    output logic                       err_o,
    output logic [32*NUM_REGS-1:0]     regs_o,
    output logic [NUM_REGS-1:0]        wr_pulse_o
);

    // Handshake: a request is accepted in any cycle where req_i && gnt_o at the
    // rising edge; gnt_o follows req_i, so every request is taken immediately and
    // its response (rvalid_o with rdata_o/err_o) appears exactly one cycle later.

    logic [31:0]         regs_q [NUM_REGS];
    logic [15:0]         err_cnt_q;
    logic [31:0]         last_err_addr_q;

    logic [7:0]          off;
    logic [3:0]          reg_idx;
    logic                hit;
    logic                aligned;
    logic                sel_reg;
    logic                sel_cnt;
    logic                sel_lea;
    logic                acc_err;
    logic [31:0]         rd_word;
    logic [NUM_REGS-1:0] wr_hit;

    assign gnt_o = req_i & rst_ni;

    always_comb begin
        off     = addr_i[7:0];
        reg_idx = off[5:2];
        hit     = (addr_i[31:8] == BASE_ADDR[31:8]);
        aligned = (addr_i[1:0] == 2'b00);
        sel_reg = (off[7:6] == 2'b00) && ({28'd0, reg_idx} < 32'(NUM_REGS));
        sel_cnt = (off == 8'h40);
        sel_lea = (off == 8'h44);
        acc_err = !hit || !aligned || !(sel_reg || sel_cnt || sel_lea);
        rd_word = '0;
        wr_hit  = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (sel_reg && (reg_idx == 4'(k))) begin
                rd_word   = regs_q[k];
                wr_hit[k] = req_i && we_i && (be_i != 4'b0000) && !acc_err;
            end
        end
        if (sel_cnt) rd_word = {16'd0, err_cnt_q};
        if (sel_lea) rd_word = last_err_addr_q;
    end

    // Byte-lane merge into the addressed config register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_hit[k]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be_i[b]) regs_q[k][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q       <= '0;
            last_err_addr_q <= '0;
        end else if (req_i && acc_err) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            last_err_addr_q <= addr_i;
        end else if (req_i && we_i && sel_cnt && (be_i != 4'b0000)) begin
            err_cnt_q <= '0;
        end
    end

    // rdata_o keeps its last value between responses; err_o is cleared.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_o   <= 1'b0;
            rdata_o    <= '0;
            err_o      <= 1'b0;
            wr_pulse_o <= '0;
        end else begin
            rvalid_o   <= req_i;
            wr_pulse_o <= wr_hit;
            if (req_i) begin
                err_o   <= acc_err;
                rdata_o <= acc_err ? ERR_RDATA : (we_i ? 32'd0 : rd_word);
            end else begin
                err_o   <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
        assign regs_o[32*k +: 32] = regs_q[k];
    end

endmodule

// File: tb/tb_sap_safe_reg_responder.sv
// Self-checking bench for sap_safe_reg_responder: directed cases from the test
// plan plus randomized traffic scored against a behavioural register model.
module tb_sap_safe_reg_responder;

  localparam int NUM_REGS = 8;
  localparam logic [31:0] ERR_RDATA = 32'hBADA_CCE5;

  logic                   clk_i;
  logic                   rst_ni;
  logic                   req_i;
  logic                   gnt_o;
  logic [31:0]            addr_i;
  logic                   we_i;
  logic [3:0]             be_i;
  logic [31:0]            wdata_i;
  logic                   rvalid_o;
  logic [31:0]            rdata_o;
  logic                   err_o;
  logic [32*NUM_REGS-1:0] regs_o;
  logic [NUM_REGS-1:0]    wr_pulse_o;

  sap_safe_reg_responder #(
    .BASE_ADDR (32'h2000_0000),
    .NUM_REGS  (NUM_REGS),
    .ERR_RDATA (ERR_RDATA)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .addr_i     (addr_i),
    .we_i       (we_i),
    .be_i       (be_i),
    .wdata_i    (wdata_i),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // scoreboard: expected {err, rdata} per accepted request
  logic [32:0] exp_q[$];

  // behavioural model of the CSR window
  logic [31:0] m_regs [NUM_REGS];
  int          m_cnt;
  logic [31:0] m_lea;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_REGS; k++) m_regs[k] = 32'd0;
    m_cnt = 0;
    m_lea = 32'd0;
    exp_q.delete();
  endtask

  function automatic logic [255:0] model_regs();
    logic [255:0] v = '0;
    for (int k = 0; k < NUM_REGS; k++) v[32*k +: 32] = m_regs[k];
    return v;
  endfunction

  // Applies one access to the model; returns the response and the pulse vector.
  task automatic model_step(input logic [31:0] addr, input logic we, input logic [3:0] be,
                            input logic [31:0] wdata, output logic [32:0] resp,
                            output logic [NUM_REGS-1:0] pulse);
    int  off;
    bit  mapped;
    off    = int'(addr[7:0]);
    mapped = (off < 4 * NUM_REGS) || (off == 'h40) || (off == 'h44);
    pulse  = '0;
    if (addr[31:8] != 24'h20_0000 || addr[1:0] != 2'b00 || !mapped) begin
      if (m_cnt < 65535) m_cnt++;
      m_lea = addr;
      resp  = {1'b1, ERR_RDATA};
    end else if (we) begin
      if (off < 4 * NUM_REGS) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) m_regs[off / 4][8*b +: 8] = wdata[8*b +: 8];
        if (be != 4'b0000) pulse[off / 4] = 1'b1;
      end else if (off == 'h40 && be != 4'b0000) begin
        m_cnt = 0;
      end
      resp = {1'b0, 32'd0};
    end else begin
      if (off < 4 * NUM_REGS)  resp = {1'b0, m_regs[off / 4]};
      else if (off == 'h40)    resp = {1'b0, 16'd0, 16'(m_cnt)};
      else                     resp = {1'b0, m_lea};
    end
  endtask

  // driver: call at a negedge; leaves req_i high so calls chain back-to-back
  task automatic xfer(input string tag, input logic [31:0] addr, input logic we,
                      input logic [3:0] be, input logic [31:0] wdata);
    logic [32:0]         resp;
    logic [32:0]         got;
    logic [NUM_REGS-1:0] pulse;
    req_i = 1'b1; addr_i = addr; we_i = we; be_i = be; wdata_i = wdata;
    #1;
    check({tag, ".gnt"}, 256'(gnt_o), 256'(1'b1));
    model_step(addr, we, be, wdata, resp, pulse);
    exp_q.push_back(resp);
    @(posedge clk_i);
    @(negedge clk_i);
    check({tag, ".rvalid"}, 256'(rvalid_o), 256'(1'b1));
    got = exp_q.pop_front();
    check({tag, ".resp"}, 256'({err_o, rdata_o}), 256'(got));
    check({tag, ".pulse"}, 256'(wr_pulse_o), 256'(pulse));
    check({tag, ".regs"}, 256'(regs_o), model_regs());
  endtask

  task automatic idle(input string tag);
    req_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check({tag, ".rvalid0"}, 256'(rvalid_o), 256'(1'b0));
    check({tag, ".pulse0"}, 256'(wr_pulse_o), 256'(0));
  endtask

  function automatic logic [31:0] rand_addr();
    int sel = $urandom_range(0, 9);
    if (sel <= 5)      return 32'h2000_0000 | 32'($urandom_range(0, NUM_REGS - 1) * 4);
    else if (sel == 6) return 32'h2000_0040;
    else if (sel == 7) return 32'h2000_0044;
    else if (sel == 8) return 32'h2000_0000 | 32'($urandom_range(0, 255));
    else               return $urandom;
  endfunction

  initial begin
    req_i = 1'b1; addr_i = 32'h2000_0000; we_i = 1'b0; be_i = 4'hF; wdata_i = 32'd0;
    rst_ni = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset.gnt", 256'(gnt_o), 256'(1'b0));
    check("reset.rvalid", 256'(rvalid_o), 256'(1'b0));
    check("reset.regs", 256'(regs_o), 256'(0));
    check("reset.rdata", 256'(rdata_o), 256'(0));
    req_i = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk_i);

    xfer("rd_reg1", 32'h2000_0004, 1'b0, 4'hF, 32'd0);
    idle("idle1");

    xfer("wr_reg2", 32'h2000_0008, 1'b1, 4'b0101, 32'hAABB_CCDD);
    idle("wr_reg2_after");
    xfer("rd_reg2", 32'h2000_0008, 1'b0, 4'h0, 32'd0);
    check("rd_reg2.value", 256'(rdata_o), 256'(32'h00BB_00DD));

    xfer("b2b_wr", 32'h2000_0000, 1'b1, 4'hF, 32'h1234_5678);
    xfer("b2b_rd", 32'h2000_0000, 1'b0, 4'hF, 32'd0);
    check("b2b_rd.value", 256'(rdata_o), 256'(32'h1234_5678));

    xfer("err_misalign", 32'h2000_0003, 1'b0, 4'hF, 32'd0);
    xfer("err_unmapped", 32'h2000_0080, 1'b1, 4'hF, 32'hFFFF_FFFF);
    xfer("err_miss", 32'h1900_0000, 1'b0, 4'hF, 32'd0);
    xfer("rd_cnt", 32'h2000_0040, 1'b0, 4'hF, 32'd0);
    check("rd_cnt.value", 256'(rdata_o), 256'(32'd3));
    xfer("rd_lea", 32'h2000_0044, 1'b0, 4'hF, 32'd0);
    check("rd_lea.value", 256'(rdata_o), 256'(32'h1900_0000));
    xfer("wr_lea_ignored", 32'h2000_0044, 1'b1, 4'hF, 32'h5555_5555);
    xfer("wr_be0", 32'h2000_0004, 1'b1, 4'h0, 32'hFFFF_FFFF);
    idle("idle2");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) idle("rnd_idle");
      else xfer("rnd", rand_addr(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
    end

    // saturation: a long burst of out-of-window reads
    req_i = 1'b1; addr_i = 32'h3000_0000; we_i = 1'b0; be_i = 4'hF;
    repeat (65537) @(posedge clk_i);
    m_cnt = 65535;
    m_lea = 32'h3000_0000;
    @(negedge clk_i);
    check("sat.err", 256'({rvalid_o, err_o, rdata_o}), 256'({2'b11, ERR_RDATA}));
    xfer("rd_cnt_sat", 32'h2000_0040, 1'b0, 4'hF, 32'd0);
    check("rd_cnt_sat.value", 256'(rdata_o), 256'(32'h0000_FFFF));
    xfer("clr_cnt", 32'h2000_0040, 1'b1, 4'b0010, 32'd0);
    xfer("rd_cnt_clr", 32'h2000_0040, 1'b0, 4'hF, 32'd0);
    check("rd_cnt_clr.value", 256'(rdata_o), 256'(32'd0));
    idle("idle3");

    // async reset in the response cycle of a write
    req_i = 1'b1; addr_i = 32'h2000_0004; we_i = 1'b1; be_i = 4'hF; wdata_i = 32'hCAFE_F00D;
    @(posedge clk_i);
    req_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    check("arst.rvalid", 256'(rvalid_o), 256'(1'b0));
    check("arst.regs", 256'(regs_o), 256'(0));
    check("arst.pulse", 256'(wr_pulse_o), 256'(0));
    req_i = 1'b1;
    #1;
    check("arst.gnt", 256'(gnt_o), 256'(1'b0));
    req_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle("arst_post1");
    idle("arst_post2");
    xfer("arst_rd", 32'h2000_0004, 1'b0, 4'hF, 32'd0);
    check("arst_rd.value", 256'(rdata_o), 256'(32'd0));
    idle("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sap_safe_reg_responder.md
Name: sap_safe_reg_responder

Overview:
- OBI responder for the safe-CPU CSR window, base 32'h2000_0000, size 0x100.
- Sits on the slave side of the safe-register demux port, which the initiator-side address rules route to.
- Decodes offsets and stores a bank of configuration registers with byte-enable writes.
- Returns pipelined responses with 1-cycle latency, and returns error responses with error bookkeeping for unmapped or misaligned accesses.

Parameters:
- BASE_ADDR, 32'h2000_0000, window base; compared on addr_i[31:8].
- NUM_REGS, 8, number of R/W 32-bit config registers at offsets 0x00..4*(NUM_REGS-1); legal range 1..16.
- ERR_RDATA, 32'hBADA_CCE5, rdata_o value returned on an error response.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  OBI request valid
- gnt_o  out  1  OBI grant
- addr_i  in  32  byte address
- we_i  in  1  1 = write, 0 = read
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid
- rdata_o  out  32  read data
- err_o  out  1  error response flag, valid with rvalid_o
- regs_o  out  32*NUM_REGS  current register values; reg k at bits [32k+31:32k]
- wr_pulse_o  out  NUM_REGS  1-cycle pulse after register k is written with be_i != 0

Behaviour:
- Clock/reset: one clock, clk_i. Reset is asynchronous active-low on rst_ni, fixed.
- Reset values: all config registers 0; ERR_CNT 0; LAST_ERR_ADDR 0; rvalid_o 0; err_o 0; rdata_o 0; wr_pulse_o 0.
- Grant: gnt_o = req_i combinationally; gnt_o = 0 while rst_ni = 0. Every request is accepted in its request cycle, so back-to-back throughput is 1 per cycle.
- Response timing: a request accepted at edge N gives rvalid_o = 1 for exactly the cycle after edge N (1-cycle latency), with rdata_o/err_o. With no accept, rvalid_o = 0 and rdata_o holds its last value.
- Decode: hit = (addr_i[31:8] == BASE_ADDR[31:8]); off = addr_i[7:0].
  - 0x00..4*(NUM_REGS-1): REG[k], k = off>>2, R/W.
  - 0x40: ERR_CNT, 16-bit, zero-extended on read. A write with any be_i clears it to 0; no error.
  - 0x44: LAST_ERR_ADDR, RO. Writes are ignored and are not an error.
- Error access: any of
  - !hit;
  - addr_i[1:0] != 0;
  - off not listed in the decode map.
- Error response:
  - No state change except error bookkeeping.
  - Response has err_o = 1 and rdata_o = ERR_RDATA.
  - ERR_CNT increments and saturates at 16'hFFFF.
  - LAST_ERR_ADDR <= addr_i.
- Write merge: byte lane b of REG[k] is updated iff be_i[b], taking effect at the accept edge. be_i = 0: no update, no wr_pulse, normal response (err_o = 0).
- Write responses: rdata_o = 0, err_o = 0.
- Reads: be_i is ignored; returns the full word sampled at the accept edge.
- Read-after-write: a read accepted the cycle after a write to the same register returns the new value. A write and a read cannot coincide, since there is only one request per cycle.
- wr_pulse_o[k]: registered; high the cycle after the accepting edge, aligned with rvalid_o.
- Reset mid-transaction: pending response dropped, rvalid_o forced 0 immediately (async), all state to reset values.

Test Plan:
- Reset → regs_o = 0, rvalid_o = 0, gnt_o = 0 while rst_ni = 0. After release, read 0x2000_0004 → rvalid one cycle later, rdata 0, err 0.
- Write 0x2000_0008, be=4'b0101, wdata=32'hAABBCCDD → next cycle rvalid, err 0, wr_pulse_o[2] = 1 for one cycle. Then read → 32'h00BB00DD.
- Back-to-back: write REG0 = 32'h1234_5678 then read REG0 in consecutive cycles → gnt high both cycles; second response rdata 32'h1234_5678.
- Errors: read 0x2000_0003, then write 0x2000_0080, then read 0x1900_0000 → each err=1 with rdata 32'hBADACCE5. ERR_CNT reads 3; LAST_ERR_ADDR reads 32'h1900_0000. REG values are unchanged.
- Saturation/clear: force 65 537 errors → ERR_CNT = 16'hFFFF. Write 0x2000_0040 → err 0; ERR_CNT reads 0.
- Async reset asserted mid-cycle, the cycle after a write was accepted → rvalid_o drops immediately, the write is lost, REG = 0; no response after release.
